// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection scheduler: the phase enumeration
// (its 3-bit encoding is exported on the `phase` output) and the default
// phase durations.
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        RED_A = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        RED_B = 3'd5,
        PED   = 3'd6
    } phase_e;

    // Default durations; all phase durations are in ticks.
    localparam int DEF_TICK_DIV  = 20;
    localparam int DEF_MIN_GREEN = 5;
    localparam int DEF_MAX_GREEN = 10;
    localparam int DEF_YELLOW    = 2;
    localparam int DEF_ALL_RED   = 1;
    localparam int DEF_WALK      = 4;

endpackage : traffic_pkg

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   tick  out high for the single cycle in which the counter is TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] L_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == L_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded from the count, so the tick is low while reset holds r_cnt at 0.
    assign tick = (r_cnt == L_LAST);

endmodule : tick_gen

// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
// Demand-driven phase controller for a two-road intersection with a
// pedestrian crossing. Greens honour minimum/maximum dwell against
// conflicting demand; a walk phase is inserted after all-red clearance when
// a pedestrian request is pending.
//
// Ports:
//   clk              in  system clock, rising edge
//   rst_n            in  asynchronous active-low reset
//   ns_req, ew_req   in  vehicle sensors (level)
//   ped_btn          in  pedestrian button (level or pulse)
//   ns_g/ns_y/ns_r   out NS lamps, one-hot
//   ew_g/ew_y/ew_r   out EW lamps, one-hot
//   walk             out pedestrian walk lamp
//   tick_o           out internal tick, one-cycle pulse
//   phase            out current phase encoding (traffic_pkg::phase_e)
// -----------------------------------------------------------------------------
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW    = DEF_YELLOW,
    parameter int ALL_RED   = DEF_ALL_RED,
    parameter int WALK      = DEF_WALK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_btn,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       walk,
    output logic       tick_o,
    output logic [2:0] phase
);

    // The dwell counter is sized for MAX_GREEN and shared by every phase, so
    // no duration may exceed it.
    if (MIN_GREEN > MAX_GREEN || YELLOW > MAX_GREEN ||
        ALL_RED > MAX_GREEN || WALK > MAX_GREEN) begin : g_bad_duration
        $error("intersection_scheduler: every duration must be <= MAX_GREEN");
    end
    if (TICK_DIV < 2 || MIN_GREEN < 1 || YELLOW < 1 ||
        ALL_RED < 1 || WALK < 1) begin : g_bad_param
        $error("intersection_scheduler: TICK_DIV >= 2 and durations >= 1 required");
    end

    localparam int NW = $clog2(MAX_GREEN + 1);
    typedef logic [NW-1:0] dwell_t;

    localparam dwell_t L_MIN  = dwell_t'(MIN_GREEN);
    localparam dwell_t L_MAX  = dwell_t'(MAX_GREEN);
    localparam dwell_t L_YEL  = dwell_t'(YELLOW);
    localparam dwell_t L_AR   = dwell_t'(ALL_RED);
    localparam dwell_t L_WALK = dwell_t'(WALK);

    phase_e r_state;
    phase_e w_next_state;
    dwell_t r_n;
    dwell_t w_n_inc;
    logic   r_ped_pend;
    logic   r_next_ew;
    logic   w_tick;
    logic   w_ped_demand;
    logic   w_enter_ped;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Decisions use the dwell value after this tick's increment.
    assign w_n_inc = (r_n == L_MAX) ? r_n : r_n + 1'b1;

    // A press on the decision cycle itself counts before it reaches the latch.
    assign w_ped_demand = r_ped_pend | ped_btn;

    assign w_enter_ped = (w_next_state == PED) && (r_state != PED);

    // NOTE: every always_comb output is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        ns_g = 1'b0;
        ns_y = 1'b0;
        ns_r = 1'b0;
        ew_g = 1'b0;
        ew_y = 1'b0;
        ew_r = 1'b0;
        walk = 1'b0;

        if (w_tick) begin
            case (r_state)
                NS_G: begin
                    if ((ew_req || w_ped_demand) &&
                        ((w_n_inc >= L_MIN && !ns_req) || w_n_inc >= L_MAX)) begin
                        w_next_state = NS_Y;
                    end
                end
                NS_Y: begin
                    if (w_n_inc >= L_YEL) w_next_state = RED_A;
                end
                RED_A: begin
                    if (w_n_inc >= L_AR) w_next_state = w_ped_demand ? PED : EW_G;
                end
                EW_G: begin
                    if ((ns_req || w_ped_demand) &&
                        ((w_n_inc >= L_MIN && !ew_req) || w_n_inc >= L_MAX)) begin
                        w_next_state = EW_Y;
                    end
                end
                EW_Y: begin
                    if (w_n_inc >= L_YEL) w_next_state = RED_B;
                end
                RED_B: begin
                    if (w_n_inc >= L_AR) w_next_state = w_ped_demand ? PED : NS_G;
                end
                PED: begin
                    if (w_n_inc >= L_WALK) w_next_state = r_next_ew ? EW_G : NS_G;
                end
                default: w_next_state = NS_G;
            endcase
        end

        // Moore lamp decode from the registered phase.
        case (r_state)
            NS_G:    begin ns_g = 1'b1; ew_r = 1'b1; end
            NS_Y:    begin ns_y = 1'b1; ew_r = 1'b1; end
            EW_G:    begin ew_g = 1'b1; ns_r = 1'b1; end
            EW_Y:    begin ew_y = 1'b1; ns_r = 1'b1; end
            PED:     begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
            default: begin ns_r = 1'b1; ew_r = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= NS_G;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dwell counter: cleared on every phase change, otherwise counts ticks
    // and saturates at MAX_GREEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= '0;
        end else if (w_next_state != r_state) begin
            r_n <= '0;
        end else if (w_tick) begin
            r_n <= w_n_inc;
        end
    end

    // Pedestrian latch: entering PED serves the request, and presses while
    // walking are ignored. next_ew remembers which green follows the walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ped_pend <= 1'b0;
            r_next_ew  <= 1'b1;
        end else begin
            if (w_enter_ped) begin
                r_ped_pend <= 1'b0;
            end else if (ped_btn && r_state != PED) begin
                r_ped_pend <= 1'b1;
            end

            if (w_enter_ped) begin
                r_next_ew <= (r_state == RED_A);
            end
        end
    end

    assign tick_o = w_tick;
    assign phase  = r_state;

endmodule : intersection_scheduler
